// File: rtl/beta_pkg.sv
// ============================================================================
//  Module      : beta_pkg
//  Description : Shared types and instruction-field constants for the beta
//                pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package beta_pkg;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_FULL  = 2'd1,
        WB_WAIT  = 2'd2
    } wb_state_t;

    localparam int unsigned R31    = 31;
    localparam int unsigned RC_HI  = 25;
    localparam int unsigned RC_LO  = 21;
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned RC_W   = RC_HI - RC_LO + 1;

endpackage

`default_nettype wire

// File: rtl/wb_wait_timer.sv
// ============================================================================
//  Module      : wb_wait_timer
//  Description : Saturating load-wait counter; flags when LD_TIMEOUT reached.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_wait_timer
    import beta_pkg::*;
#(
    parameter int unsigned LD_TIMEOUT = 15,
    parameter int unsigned CW         = $clog2(LD_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [CW-1:0] c_limit = CW'(LD_TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign o_at_limit = (count_q == c_limit);

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && !o_at_limit) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
//  Module      : wb_stage
//  Description : Write-back stage: holds one retiring instruction, waits on
//                load data with timeout, drives RF write, bypass and counters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage
    import beta_pkg::*;
#(
    parameter  int unsigned XLEN       = 32,
    parameter  int unsigned NREGS      = 32,
    parameter  int unsigned LD_TIMEOUT = 15,
    parameter  int unsigned CNT_W      = 32,
    localparam int unsigned AW         = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_ld_or_ldr,
    input  logic             op_st,
    input  logic             rf_w_mux_jump,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  ir,
    input  logic [XLEN-1:0]  y,
    input  logic [XLEN-1:0]  mem_rd,
    input  logic             mem_rd_valid,
    output logic [XLEN-1:0]  rf_w_data,
    output logic [AW-1:0]    rf_w_addr,
    output logic             rf_we,
    output logic             byp_valid,
    output logic             byp_pending,
    output logic [AW-1:0]    byp_addr,
    output logic [XLEN-1:0]  byp_data,
    output logic [CNT_W-1:0] retired,
    output logic             mem_err
);

    localparam logic [AW-1:0] c_zero_reg = AW'(NREGS - 1);

    wb_state_t        state_q,   state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_err_q, mem_err_d;
    logic [XLEN-1:0]  pc_q, pc_d, ir_q, ir_d, y_q, y_d;
    logic             ld_q, ld_d, st_q, st_d, jmp_q, jmp_d;

    logic             w_held;
    logic             w_capture;
    logic             w_timeout;
    logic             w_at_limit;
    logic             w_complete;
    logic             w_wait_inc;
    logic             w_not_zero;
    logic [RC_W-1:0]  w_rc;
    logic             w_unused_ir;

    assign w_held     = (state_q != WB_EMPTY);
    assign w_timeout  = (state_q == WB_WAIT) && w_at_limit;
    assign w_complete = w_held && (!ld_q || mem_rd_valid || w_timeout);
    assign in_ready   = !rst && ((state_q == WB_EMPTY) || w_complete);
    assign w_capture  = in_valid && in_ready;
    assign w_wait_inc = w_held && ld_q && !w_complete;

    // Only the rc field of the held instruction word is consumed here.
    assign w_rc        = ir_q[RC_HI:RC_LO];
    assign w_unused_ir = ^{ir_q[XLEN-1:RC_HI+1], ir_q[RC_LO-1:0]};

    assign rf_w_addr  = AW'(w_rc);
    assign byp_addr   = rf_w_addr;
    assign w_not_zero = (rf_w_addr != c_zero_reg);

    // Load data outranks a jump flag; jump outranks the ALU result.
    assign rf_w_data = ld_q ? mem_rd : (jmp_q ? pc_q : y_q);
    assign byp_data  = rf_w_data;

    assign rf_we       = !rst && w_complete && !st_q && !w_timeout && w_not_zero;
    assign byp_valid   = !rst && w_held && !st_q && w_not_zero && (!ld_q || mem_rd_valid);
    assign byp_pending = !rst && w_held && ld_q && !mem_rd_valid && w_not_zero;
    assign retired     = retired_q;
    assign mem_err     = mem_err_q;

    wb_wait_timer #(
        .LD_TIMEOUT (LD_TIMEOUT)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_capture),
        .i_inc      (w_wait_inc),
        .o_at_limit (w_at_limit)
    );

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q + CNT_W'(w_complete);
        mem_err_d = mem_err_q || w_timeout;
        pc_d      = pc_q;
        ir_d      = ir_q;
        y_d       = y_q;
        ld_d      = ld_q;
        st_d      = st_q;
        jmp_d     = jmp_q;
        if (w_capture) begin
            state_d = WB_FULL;
            pc_d    = pc;
            ir_d    = ir;
            y_d     = y;
            ld_d    = op_ld_or_ldr;
            st_d    = op_st;
            jmp_d   = rf_w_mux_jump;
        end else if (w_complete) begin
            state_d = WB_EMPTY;
        end else if (w_held && ld_q) begin
            state_d = WB_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WB_EMPTY;
            retired_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q  <= pc_d;
        ir_q  <= ir_d;
        y_q   <= y_d;
        ld_q  <= ld_d;
        st_q  <= st_d;
        jmp_q <= jmp_d;
    end

endmodule

`default_nettype wire
